id_ex_stage_reg: RTL and testbench

- Pipeline register between the instruction-decode stage (register-file reads, control decode) and the execute stage of the 5-stage ARM-subset core.
- Captures decoded control, immediates, PC and the two register-file operand values on each rising clock edge.
- Supports hazard freeze and branch flush.
- While frozen, snoops the write-back bus so that held operand values never go stale.

---
 rtl/id_ex_stage_reg_if.sv | 65 ++++++
 rtl/id_ex_stage_reg.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// rtl/id_ex_stage_reg_if.sv - ID/EXE stage-register bundle: ID fields in, EXE fields out, write-back snoop bus
interface id_ex_stage_reg_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              flush;
    logic              freeze;
    logic              in_valid;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] val_rn_in;
    logic [DATA_W-1:0] val_rm_in;
    logic [REG_AW-1:0] src1_in;
    logic [REG_AW-1:0] src2_in;
    logic [REG_AW-1:0] dest_in;
    logic [3:0]        exe_cmd_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;
    logic              b_in;
    logic              s_in;
    logic              imm_in;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm24_in;
    logic              carry_in;
    logic              wb_wr_en;
    logic [REG_AW-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic              out_valid;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] val_rn_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [REG_AW-1:0] src1_out;
    logic [REG_AW-1:0] src2_out;
    logic [REG_AW-1:0] dest_out;
    logic [3:0]        exe_cmd_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              wb_en_out;
    logic              b_out;
    logic              s_out;
    logic              imm_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm24_out;
    logic              carry_out;

    modport master (
        output flush, freeze, in_valid, pc_in, val_rn_in, val_rm_in, src1_in, src2_in, dest_in,
               exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
               shift_operand_in, signed_imm24_in, carry_in, wb_wr_en, wb_dest, wb_value,
        input  out_valid, pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
               exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
               shift_operand_out, signed_imm24_out, carry_out
    );

    modport slave (
        input  flush, freeze, in_valid, pc_in, val_rn_in, val_rm_in, src1_in, src2_in, dest_in,
               exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
               shift_operand_in, signed_imm24_in, carry_in, wb_wr_en, wb_dest, wb_value,
        output out_valid, pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
               exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
               shift_operand_out, signed_imm24_out, carry_out
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EXE pipeline register with flush, freeze and write-back operand snooping
module id_ex_stage_reg #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    id_ex_stage_reg_if.slave    bus
);
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] val_rn_q, val_rn_d;
    logic [DATA_W-1:0] val_rm_q, val_rm_d;
    logic [REG_AW-1:0] src1_q, src1_d;
    logic [REG_AW-1:0] src2_q, src2_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [3:0]        exe_cmd_q, exe_cmd_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              wb_en_q, wb_en_d;
    logic              b_q, b_d;
    logic              s_q, s_d;
    logic              imm_q, imm_d;
    logic [11:0]       shift_operand_q, shift_operand_d;
    logic [23:0]       signed_imm24_q, signed_imm24_d;
    logic              carry_q, carry_d;

    always_comb begin
        valid_d         = valid_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        dest_d          = dest_q;
        exe_cmd_d       = exe_cmd_q;
        mem_r_en_d      = mem_r_en_q;
        mem_w_en_d      = mem_w_en_q;
        wb_en_d         = wb_en_q;
        b_d             = b_q;
        s_d             = s_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        signed_imm24_d  = signed_imm24_q;
        carry_d         = carry_q;

        if (bus.flush) begin
            valid_d         = 1'b0;
            pc_d            = '0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            src1_d          = '0;
            src2_d          = '0;
            dest_d          = '0;
            exe_cmd_d       = '0;
            mem_r_en_d      = 1'b0;
            mem_w_en_d      = 1'b0;
            wb_en_d         = 1'b0;
            b_d             = 1'b0;
            s_d             = 1'b0;
            imm_d           = 1'b0;
            shift_operand_d = '0;
            signed_imm24_d  = '0;
            carry_d         = 1'b0;
        end else if (bus.freeze) begin
            // Held operands track the register file so the stalled instruction never sees stale data
            if (bus.wb_wr_en && (bus.wb_dest == src1_q)) val_rn_d = bus.wb_value;
            if (bus.wb_wr_en && (bus.wb_dest == src2_q)) val_rm_d = bus.wb_value;
        end else begin
            valid_d         = bus.in_valid;
            pc_d            = bus.pc_in;
            val_rn_d        = bus.val_rn_in;
            val_rm_d        = bus.val_rm_in;
            src1_d          = bus.src1_in;
            src2_d          = bus.src2_in;
            dest_d          = bus.dest_in;
            exe_cmd_d       = bus.exe_cmd_in;
            mem_r_en_d      = bus.mem_r_en_in;
            mem_w_en_d      = bus.mem_w_en_in;
            wb_en_d         = bus.wb_en_in;
            b_d             = bus.b_in;
            s_d             = bus.s_in;
            imm_d           = bus.imm_in;
            shift_operand_d = bus.shift_operand_in;
            signed_imm24_d  = bus.signed_imm24_in;
            carry_d         = bus.carry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= 1'b0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            dest_q          <= '0;
            exe_cmd_q       <= '0;
            mem_r_en_q      <= 1'b0;
            mem_w_en_q      <= 1'b0;
            wb_en_q         <= 1'b0;
            b_q             <= 1'b0;
            s_q             <= 1'b0;
            imm_q           <= 1'b0;
            shift_operand_q <= '0;
            signed_imm24_q  <= '0;
            carry_q         <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            dest_q          <= dest_d;
            exe_cmd_q       <= exe_cmd_d;
            mem_r_en_q      <= mem_r_en_d;
            mem_w_en_q      <= mem_w_en_d;
            wb_en_q         <= wb_en_d;
            b_q             <= b_d;
            s_q             <= s_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm24_q  <= signed_imm24_d;
            carry_q         <= carry_d;
        end
    end

    assign bus.out_valid         = valid_q;
    assign bus.pc_out            = pc_q;
    assign bus.val_rn_out        = val_rn_q;
    assign bus.val_rm_out        = val_rm_q;
    assign bus.src1_out          = src1_q;
    assign bus.src2_out          = src2_q;
    assign bus.dest_out          = dest_q;
    assign bus.exe_cmd_out       = exe_cmd_q;
    assign bus.mem_r_en_out      = mem_r_en_q;
    assign bus.mem_w_en_out      = mem_w_en_q;
    assign bus.wb_en_out         = wb_en_q;
    assign bus.b_out             = b_q;
    assign bus.s_out             = s_q;
    assign bus.imm_out           = imm_q;
    assign bus.shift_operand_out = shift_operand_q;
    assign bus.signed_imm24_out  = signed_imm24_q;
    assign bus.carry_out         = carry_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed bench for id_ex_stage_reg: reset, load, freeze/snoop, flush
module tb_id_ex_stage_reg;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    id_ex_stage_reg_if #(.PC_W(32), .DATA_W(32), .REG_AW(4)) bus ();

    id_ex_stage_reg #(.PC_W(32), .DATA_W(32), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] off;
        logic        c;
    } stage_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input stage_t v);
        bus.in_valid         = v.valid;
        bus.pc_in            = v.pc;
        bus.val_rn_in        = v.rn;
        bus.val_rm_in        = v.rm;
        bus.src1_in          = v.s1;
        bus.src2_in          = v.s2;
        bus.dest_in          = v.d;
        bus.exe_cmd_in       = v.cmd;
        bus.mem_r_en_in      = v.mr;
        bus.mem_w_en_in      = v.mw;
        bus.wb_en_in         = v.wb;
        bus.b_in             = v.b;
        bus.s_in             = v.s;
        bus.imm_in           = v.imm;
        bus.shift_operand_in = v.sh;
        bus.signed_imm24_in  = v.off;
        bus.carry_in         = v.c;
    endtask

    task automatic expect_all(input string tag, input stage_t e);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e.valid));
        chk({tag, ".pc"},        bus.pc_out, e.pc);
        chk({tag, ".val_rn"},    bus.val_rn_out, e.rn);
        chk({tag, ".val_rm"},    bus.val_rm_out, e.rm);
        chk({tag, ".src1"},      32'(bus.src1_out), 32'(e.s1));
        chk({tag, ".src2"},      32'(bus.src2_out), 32'(e.s2));
        chk({tag, ".dest"},      32'(bus.dest_out), 32'(e.d));
        chk({tag, ".exe_cmd"},   32'(bus.exe_cmd_out), 32'(e.cmd));
        chk({tag, ".ctrl"},      32'({bus.mem_r_en_out, bus.mem_w_en_out, bus.wb_en_out,
                                      bus.b_out, bus.s_out, bus.imm_out}),
                                 32'({e.mr, e.mw, e.wb, e.b, e.s, e.imm}));
        chk({tag, ".shift"},     32'(bus.shift_operand_out), 32'(e.sh));
        chk({tag, ".imm24"},     32'(bus.signed_imm24_out), 32'(e.off));
        chk({tag, ".carry"},     32'(bus.carry_out), 32'(e.c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    stage_t zero, va, vb, vc, vd, exp_s;

    initial begin
        vectors = 0;
        miscompares = 0;
        zero = '{default: '0};
        va = zero;
        va.valid = 1'b1; va.pc = 32'h10; va.rn = 32'hA; va.d = 4'd3; va.wb = 1'b1;
        vb = '{valid: 1'b1, pc: 32'h20, rn: 32'h5, rm: 32'h77, s1: 4'd5, s2: 4'd7, d: 4'd9,
               cmd: 4'h4, mr: 1'b1, mw: 1'b0, wb: 1'b1, b: 1'b0, s: 1'b1, imm: 1'b0,
               sh: 12'hABC, off: 24'h123456, c: 1'b1};
        vc = '{valid: 1'b1, pc: 32'h30, rn: 32'h11, rm: 32'h22, s1: 4'd2, s2: 4'd2, d: 4'd1,
               cmd: 4'h9, mr: 1'b0, mw: 1'b1, wb: 1'b0, b: 1'b1, s: 1'b0, imm: 1'b1,
               sh: 12'h5A5, off: 24'hFEDCBA, c: 1'b0};
        vd = '{valid: 1'b1, pc: 32'hFFFF_FFFC, rn: 32'hCAFE_F00D, rm: 32'h8000_0001, s1: 4'd15,
               s2: 4'd0, d: 4'd14, cmd: 4'hF, mr: 1'b1, mw: 1'b1, wb: 1'b1, b: 1'b1, s: 1'b1,
               imm: 1'b1, sh: 12'hFFF, off: 24'h800000, c: 1'b1};

        rst = 1'b1;
        bus.flush = 1'b0; bus.freeze = 1'b0;
        bus.wb_wr_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;
        drive(vb);
        tick();
        expect_all("reset_hold", zero);
        rst = 1'b0;

        drive(va);
        tick();
        expect_all("load_a", va);

        drive(vb);
        tick();
        expect_all("load_b", vb);

        // Freeze with a matching write-back on src1 only; ID inputs change underneath
        drive(vd);
        bus.freeze = 1'b1; bus.wb_wr_en = 1'b1; bus.wb_dest = 4'd5; bus.wb_value = 32'hDEAD;
        tick();
        exp_s = vb; exp_s.rn = 32'hDEAD;
        expect_all("snoop_src1", exp_s);

        bus.wb_dest = 4'd9; bus.wb_value = 32'h1111_2222;
        tick();
        expect_all("snoop_nomatch", exp_s);

        bus.wb_wr_en = 1'b0; bus.wb_dest = 4'd7;
        tick();
        expect_all("snoop_wr_en_low", exp_s);

        // Asynchronous reset mid-cycle
        bus.freeze = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_all("async_reset", zero);
        #1 rst = 1'b0;

        drive(vc);
        tick();
        expect_all("load_c", vc);

        bus.freeze = 1'b1; bus.wb_wr_en = 1'b1; bus.wb_dest = 4'd2; bus.wb_value = 32'h1234;
        drive(vd);
        tick();
        exp_s = vc; exp_s.rn = 32'h1234; exp_s.rm = 32'h1234;
        expect_all("snoop_both", exp_s);

        bus.flush = 1'b1;
        tick();
        expect_all("flush_over_freeze", zero);

        bus.flush = 1'b0; bus.freeze = 1'b0; bus.wb_wr_en = 1'b0;
        drive(vb);
        tick();
        expect_all("reload_b", vb);

        // Three frozen cycles while the ID side presents a new instruction
        bus.freeze = 1'b1;
        drive(vd);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all($sformatf("freeze_hold%0d", i), vb);
        end
        bus.freeze = 1'b0;
        tick();
        expect_all("freeze_release", vd);

        // Plain flush produces a bubble even with a valid ID instruction
        drive(va);
        bus.flush = 1'b1;
        tick();
        expect_all("flush_bubble", zero);

        // Snooping on a bubble updates operands but keeps it a bubble
        bus.flush = 1'b0; bus.freeze = 1'b1;
        bus.wb_wr_en = 1'b1; bus.wb_dest = 4'd0; bus.wb_value = 32'hFFFF_FFFF;
        tick();
        exp_s = zero; exp_s.rn = 32'hFFFF_FFFF; exp_s.rm = 32'hFFFF_FFFF;
        expect_all("snoop_bubble", exp_s);

        bus.freeze = 1'b0; bus.wb_wr_en = 1'b0;
        tick();
        expect_all("load_after_bubble", va);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
